// File: rtl/zx_audio_pkg.sv
// rtl/zx_audio_pkg.sv - shared levels, enums and saturating add for the zx_audio_dac path
package zx_audio_pkg;
    localparam int          DAC_W_DEF    = 12;
    localparam logic [11:0] BEEP_LVL_DEF = 12'h300;
    localparam logic [11:0] MIC_LVL_DEF  = 12'h060;
    localparam logic [11:0] TAPE_LVL_DEF = 12'h100;

    typedef enum logic [1:0] {SM_ABC, SM_ACB, SM_MONO, SM_BEEP} stereo_mode_t;
    typedef enum logic [1:0] {RUN, FADE_OUT, MUTED, FADE_IN} fade_state_t;

    function automatic logic [11:0] sat12(input logic [12:0] sum);
        return sum[12] ? 12'hFFF : sum[11:0];
    endfunction
endpackage

// File: rtl/sigma_delta_dac.sv
// rtl/sigma_delta_dac.sv - first-order sigma-delta modulator, carry out of the accumulator is the bitstream
module sigma_delta_dac #(
    parameter int DAC_W = 12
) (
    input  logic             clk_sys,
    input  logic             cold_reset,
    input  logic [DAC_W-1:0] level,
    output logic             dout
);
    logic [DAC_W:0] acc;

    always_ff @(posedge clk_sys or posedge cold_reset) begin
        if (cold_reset) begin
            acc  <= '0;
            dout <= 1'b0;
        end else begin
            acc  <= {1'b0, acc[DAC_W-1:0]} + {1'b0, level};
            dout <= acc[DAC_W];
        end
    end
endmodule

// File: rtl/zx_audio_dac.sv
// rtl/zx_audio_dac.sv - beeper/tape/AY mixer with click-free fade FSM driving two sigma-delta outputs
module zx_audio_dac
    import zx_audio_pkg::*;
#(
    parameter int               DAC_W    = DAC_W_DEF,
    parameter logic [DAC_W-1:0] BEEP_LVL = BEEP_LVL_DEF,
    parameter logic [DAC_W-1:0] MIC_LVL  = MIC_LVL_DEF,
    parameter logic [DAC_W-1:0] TAPE_LVL = TAPE_LVL_DEF
) (
    input  logic       clk_sys,
    input  logic       cold_reset,
    input  logic       ce_sample,
    input  logic       ear,
    input  logic       mic,
    input  logic       tape_in,
    input  logic [7:0] psg_a,
    input  logic [7:0] psg_b,
    input  logic [7:0] psg_c,
    input  logic [1:0] stereo_mode,
    input  logic       mute,
    output logic       AUDIO_L,
    output logic       AUDIO_R,
    output logic       fading
);
    localparam logic [DAC_W-1:0] LSB = {{(DAC_W-1){1'b0}}, 1'b1};

    logic [DAC_W:0]   beep, pa, pb, pc, sum_l, sum_r;
    logic [DAC_W-1:0] t_l, t_r, t_l_next, t_r_next;
    logic [DAC_W-1:0] h_l, h_r, h_l_next, h_r_next;
    logic             fading_next;
    fade_state_t      state, state_next;

    function automatic logic [DAC_W-1:0] step_toward(input logic [DAC_W-1:0] h,
                                                     input logic [DAC_W-1:0] t);
        if (h < t) return h + LSB;
        if (h > t) return h - LSB;
        return h;
    endfunction

    always_comb begin
        pa    = (DAC_W+1)'(psg_a);
        pb    = (DAC_W+1)'(psg_b);
        pc    = (DAC_W+1)'(psg_c);
        beep  = (ear     ? (DAC_W+1)'(BEEP_LVL) : '0)
              + (mic     ? (DAC_W+1)'(MIC_LVL)  : '0)
              + (tape_in ? (DAC_W+1)'(TAPE_LVL) : '0);
        sum_l = beep;
        sum_r = beep;
        case (stereo_mode_t'(stereo_mode))
            SM_ABC:  begin sum_l = beep + (pa << 1) + pb; sum_r = beep + (pc << 1) + pb; end
            SM_ACB:  begin sum_l = beep + (pa << 1) + pc; sum_r = beep + (pb << 1) + pc; end
            SM_MONO: begin sum_l = beep + pa + pb + pc;   sum_r = beep + pa + pb + pc;   end
            SM_BEEP: ;
        endcase
        t_l_next = ce_sample ? sat12(sum_l) : t_l;
        t_r_next = ce_sample ? sat12(sum_r) : t_r;
    end

    always_ff @(posedge clk_sys or posedge cold_reset) begin
        if (cold_reset) begin
            t_l <= '0;
            t_r <= '0;
        end else begin
            t_l <= t_l_next;
            t_r <= t_r_next;
        end
    end

    always_ff @(posedge clk_sys or posedge cold_reset) begin
        if (cold_reset) state <= FADE_IN;
        else            state <= state_next;
    end

    // Fade exits test the level being written this clk, so the last step and the exit coincide.
    always_comb begin
        state_next = state;
        case (state)
            RUN:      if (mute) state_next = FADE_OUT;
            FADE_OUT: if (!mute) state_next = FADE_IN;
                      else if (h_l_next == '0 && h_r_next == '0) state_next = MUTED;
            MUTED:    if (!mute) state_next = FADE_IN;
            FADE_IN:  if (mute) state_next = FADE_OUT;
                      else if (h_l_next == t_l_next && h_r_next == t_r_next) state_next = RUN;
        endcase
    end

    // A mute edge only changes direction; the level is held for the clk of the turnaround.
    always_comb begin
        h_l_next = h_l;
        h_r_next = h_r;
        case (state)
            RUN: begin
                h_l_next = t_l;
                h_r_next = t_r;
            end
            FADE_OUT: if (mute) begin
                h_l_next = (h_l != '0) ? h_l - LSB : '0;
                h_r_next = (h_r != '0) ? h_r - LSB : '0;
            end
            MUTED: begin
                h_l_next = '0;
                h_r_next = '0;
            end
            FADE_IN: if (!mute) begin
                h_l_next = step_toward(h_l, t_l_next);
                h_r_next = step_toward(h_r, t_r_next);
            end
        endcase
        fading_next = (state_next == FADE_IN) || (state_next == FADE_OUT);
    end

    always_ff @(posedge clk_sys or posedge cold_reset) begin
        if (cold_reset) begin
            h_l    <= '0;
            h_r    <= '0;
            fading <= 1'b0;
        end else begin
            h_l    <= h_l_next;
            h_r    <= h_r_next;
            fading <= fading_next;
        end
    end

    sigma_delta_dac #(.DAC_W(DAC_W)) u_dac_l (
        .clk_sys    (clk_sys),
        .cold_reset (cold_reset),
        .level      (h_l),
        .dout       (AUDIO_L)
    );

    sigma_delta_dac #(.DAC_W(DAC_W)) u_dac_r (
        .clk_sys    (clk_sys),
        .cold_reset (cold_reset),
        .level      (h_r),
        .dout       (AUDIO_R)
    );
endmodule

// File: tb/tb_zx_audio_dac.sv
// tb/tb_zx_audio_dac.sv - self-checking bench for zx_audio_dac against a cycle reference model
module tb_zx_audio_dac;
    localparam int M_RUN = 0, M_FOUT = 1, M_MUTED = 2, M_FIN = 3;

    typedef struct packed {
        int tl;
        int tr;
        int hl;
        int hr;
        int st;
        int fd;
    } mstate_t;

    logic       clk_sys = 1'b0;
    logic       cold_reset, ce_sample, ear, mic, tape_in, mute;
    logic [7:0] psg_a, psg_b, psg_c;
    logic [1:0] stereo_mode;
    logic       audio_l, audio_r, fading, hot_l, hot_r, hot_fading;
    int         checks = 0;
    int         errors = 0;
    mstate_t    m;

    always #18 clk_sys = ~clk_sys;

    zx_audio_dac dut (
        .clk_sys(clk_sys), .cold_reset(cold_reset), .ce_sample(ce_sample),
        .ear(ear), .mic(mic), .tape_in(tape_in),
        .psg_a(psg_a), .psg_b(psg_b), .psg_c(psg_c),
        .stereo_mode(stereo_mode), .mute(mute),
        .AUDIO_L(audio_l), .AUDIO_R(audio_r), .fading(fading)
    );

    zx_audio_dac #(.BEEP_LVL(12'hF00)) dut_hot (
        .clk_sys(clk_sys), .cold_reset(cold_reset), .ce_sample(ce_sample),
        .ear(ear), .mic(mic), .tape_in(tape_in),
        .psg_a(psg_a), .psg_b(psg_b), .psg_c(psg_c),
        .stereo_mode(stereo_mode), .mute(mute),
        .AUDIO_L(hot_l), .AUDIO_R(hot_r), .fading(hot_fading)
    );

    function automatic void calc_targets(input int beep_lvl, output int tl, output int tr);
        int bp = (ear ? beep_lvl : 0) + (mic ? 96 : 0) + (tape_in ? 256 : 0);
        int a = psg_a;
        int b = psg_b;
        int c = psg_c;
        case (stereo_mode)
            2'd0:    begin tl = bp + 2 * a + b; tr = bp + 2 * c + b; end
            2'd1:    begin tl = bp + 2 * a + c; tr = bp + 2 * b + c; end
            2'd2:    begin tl = bp + a + b + c; tr = tl; end
            default: begin tl = bp; tr = bp; end
        endcase
        if (tl > 4095) tl = 4095;
        if (tr > 4095) tr = 4095;
    endfunction

    function automatic int toward(input int h, input int t);
        return (h < t) ? h + 1 : (h > t) ? h - 1 : h;
    endfunction

    function automatic mstate_t model_next(input mstate_t c);
        mstate_t n = c;
        int ntl = c.tl;
        int ntr = c.tr;
        if (ce_sample) calc_targets(768, ntl, ntr);
        n.tl = ntl;
        n.tr = ntr;
        case (c.st)
            M_RUN: begin
                n.hl = c.tl;
                n.hr = c.tr;
                if (mute) n.st = M_FOUT;
            end
            M_FOUT: begin
                if (!mute) n.st = M_FIN;
                else begin
                    n.hl = (c.hl > 0) ? c.hl - 1 : 0;
                    n.hr = (c.hr > 0) ? c.hr - 1 : 0;
                    if (n.hl == 0 && n.hr == 0) n.st = M_MUTED;
                end
            end
            M_MUTED: begin
                n.hl = 0;
                n.hr = 0;
                if (!mute) n.st = M_FIN;
            end
            default: begin
                if (mute) n.st = M_FOUT;
                else begin
                    n.hl = toward(c.hl, ntl);
                    n.hr = toward(c.hr, ntr);
                    if (n.hl == ntl && n.hr == ntr) n.st = M_RUN;
                end
            end
        endcase
        n.fd = (n.st == M_FOUT || n.st == M_FIN) ? 1 : 0;
        return n;
    endfunction

    always @(posedge clk_sys or posedge cold_reset) begin
        if (cold_reset) m <= '{tl: 0, tr: 0, hl: 0, hr: 0, st: M_FIN, fd: 0};
        else            m <= model_next(m);
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        @(negedge clk_sys);
        check("t_l", int'(dut.t_l), m.tl);
        check("t_r", int'(dut.t_r), m.tr);
        check("h_l", int'(dut.h_l), m.hl);
        check("h_r", int'(dut.h_r), m.hr);
        check("fading", int'(fading), m.fd);
    endtask

    task automatic count_ones(input int cycles, output int ol, output int orr,
                              output int hl, output int hr);
        ol = 0; orr = 0; hl = 0; hr = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            ol += int'(audio_l);
            orr += int'(audio_r);
            hl += int'(hot_l);
            hr += int'(hot_r);
        end
    endtask

    task automatic ramp_until_idle(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (fading === 1'b1 && n < limit);
    endtask

    initial begin
        int n, ol, orr, hl, hr;
        cold_reset = 1'b1; ce_sample = 1'b1; ear = 1'b1; mic = 1'b0; tape_in = 1'b0;
        psg_a = 8'h00; psg_b = 8'h00; psg_c = 8'h00; stereo_mode = 2'd0; mute = 1'b0;
        repeat (3) tick();
        check("rst_audio_l", int'(audio_l), 0);
        check("rst_audio_r", int'(audio_r), 0);
        check("rst_fading", int'(fading), 0);
        check("rst_h_l", int'(dut.h_l), 0);

        cold_reset = 1'b0;
        ramp_until_idle(2000, n);
        check("startup_ramp_clks", n, 768);
        check("startup_h_l", int'(dut.h_l), 768);
        check("startup_h_r", int'(dut.h_r), 768);
        repeat (2) tick();
        count_ones(4096, ol, orr, hl, hr);
        check("startup_ones_l", ol, 768);
        check("startup_ones_r", orr, 768);

        ear = 1'b0; psg_a = 8'h10; psg_b = 8'h20; psg_c = 8'h40;
        stereo_mode = 2'd0; repeat (3) tick();
        check("abc_t_l", int'(dut.t_l), 12'h040);
        check("abc_t_r", int'(dut.t_r), 12'h0A0);
        stereo_mode = 2'd1; repeat (3) tick();
        check("acb_t_l", int'(dut.t_l), 12'h060);
        check("acb_t_r", int'(dut.t_r), 12'h080);
        stereo_mode = 2'd2; repeat (3) tick();
        check("mono_t_l", int'(dut.t_l), 12'h070);
        check("mono_t_r", int'(dut.t_r), 12'h070);
        stereo_mode = 2'd3; repeat (3) tick();
        check("beep_t_l", int'(dut.t_l), 0);
        check("beep_t_r", int'(dut.t_r), 0);

        ear = 1'b1; mic = 1'b1; tape_in = 1'b1;
        psg_a = 8'hFF; psg_b = 8'hFF; psg_c = 8'hFF; stereo_mode = 2'd0;
        repeat (3) tick();
        check("full_t_l", int'(dut.t_l), 12'h75D);
        check("full_t_r", int'(dut.t_r), 12'h75D);
        check("sat_t_l", int'(dut_hot.t_l), 12'hFFF);
        check("sat_t_r", int'(dut_hot.t_r), 12'hFFF);
        repeat (2) tick();
        count_ones(4096, ol, orr, hl, hr);
        check("full_ones_l", ol, 12'h75D);
        check("sat_ones_l", hl, 4095);
        check("sat_ones_r", hr, 4095);
        check("sat_fading", int'(hot_fading), 0);

        ear = 1'b0; mic = 1'b0; tape_in = 1'b0;
        psg_a = 8'hFF; psg_b = 8'hFF; psg_c = 8'h02; stereo_mode = 2'd2;
        repeat (4) tick();
        check("mute_start_h_l", int'(dut.h_l), 12'h200);
        mute = 1'b1;
        tick();
        check("fade_out_fading", int'(fading), 1);
        n = 0;
        do begin tick(); n++; end while (dut.h_l != 12'd0 && n < 1000);
        check("fade_out_clks", n, 512);
        check("muted_fading", int'(fading), 0);
        repeat (4) tick();
        count_ones(256, ol, orr, hl, hr);
        check("muted_ones_l", ol, 0);
        check("muted_ones_r", orr, 0);

        mute = 1'b0;
        tick();
        check("fade_in_fading", int'(fading), 1);
        n = 0;
        do begin tick(); n++; end while (dut.h_l != 12'h200 && n < 1000);
        check("fade_in_clks", n, 512);
        check("fade_in_done", int'(fading), 0);

        mute = 1'b1;
        tick();
        repeat (100) tick();
        check("abort_h_l", int'(dut.h_l), 12'h19C);
        mute = 1'b0;
        tick();
        check("abort_turn_h_l", int'(dut.h_l), 12'h19C);
        check("abort_turn_fading", int'(fading), 1);
        ramp_until_idle(1000, n);
        check("abort_return_clks", n, 100);
        check("abort_h_r", int'(dut.h_r), 12'h200);

        for (int i = 0; i < 3000; i++) begin
            ce_sample   = ($urandom_range(3) == 0);
            ear         = 1'($urandom);
            mic         = 1'($urandom);
            tape_in     = 1'($urandom);
            psg_a       = 8'($urandom);
            psg_b       = 8'($urandom);
            psg_c       = 8'($urandom);
            stereo_mode = 2'($urandom);
            if ($urandom_range(199) == 0) mute = ~mute;
            tick();
        end
        ce_sample = 1'b1; mute = 1'b0;
        ramp_until_idle(5000, n);
        check("random_settled", int'(fading), 0);

        ear = 1'b1; mic = 1'b0; tape_in = 1'b0; stereo_mode = 2'd3;
        cold_reset = 1'b1;
        tick();
        cold_reset = 1'b0;
        n = 0;
        do begin tick(); n++; end while (dut.h_l != 12'd300 && n < 1000);
        check("midfade_h_clks", n, 300);
        #5 cold_reset = 1'b1;
        #1;
        check("midfade_audio_l", int'(audio_l), 0);
        check("midfade_audio_r", int'(audio_r), 0);
        check("midfade_fading", int'(fading), 0);
        check("midfade_h_l", int'(dut.h_l), 0);
        repeat (2) tick();
        cold_reset = 1'b0;
        ramp_until_idle(2000, n);
        check("rerun_ramp_clks", n, 768);
        check("rerun_h_l", int'(dut.h_l), 768);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
